// File: rtl/mx_pkt_buf_pkg.sv
// Shared types for the per-port packet-to-CPU buffer: the stored word layout,
// the write-side state encoding and the statistics counter width.
package mx_pkt_buf_pkg;

    localparam int PKT_DATA_W = 64;
    localparam int PKT_MTY_W  = 3;
    localparam int STAT_W     = 32;

    // sop is not stored; it is rebuilt on the output side from the previous eop.
    typedef struct packed {
        logic                  eop;
        logic [PKT_MTY_W-1:0]  mty;
        logic [PKT_DATA_W-1:0] data;
    } pkt_buf_word_t;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        DISCARD
    } wr_state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mx_pkt_buf_ram.sv
// Simple dual-port RAM for the packet buffer: one write port, one read port
// with a registered (1-cycle) read.
module mx_pkt_buf_ram #(
    parameter int W  = 68,
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [0:(1<<AW)-1];
    logic [W-1:0] r_rd_data;

    // NOTE: the array has no reset; validity lives in the pointers, so stale contents are never visible.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mx_pkt_to_cpu_buf.sv
// Store-and-forward packet buffer, analyzer packet-to-CPU stream -> CPU DMA side.
// Optional statistics outputs are enabled with `define MX_PKT_BUF_STAT_EN.
module mx_pkt_to_cpu_buf
    import mx_pkt_buf_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = PKT_DATA_W,
    parameter int MTY_W  = PKT_MTY_W
) (
    input  logic                clk_156m25_i,
    input  logic                rst_i,
    input  logic                snk_val_i,
    input  logic                snk_sop_i,
    input  logic                snk_eop_i,
    input  logic [MTY_W-1:0]    snk_mty_i,
    input  logic                snk_err_i,
    input  logic [DATA_W-1:0]   snk_data_i,
    output logic                src_val_o,
    output logic                src_sop_o,
    output logic                src_eop_o,
    output logic [MTY_W-1:0]    src_mty_o,
    output logic [DATA_W-1:0]   src_data_o,
    input  logic                src_ready_i,
    output logic                pkt_drop_o
`ifdef MX_PKT_BUF_STAT_EN
    ,
    input  logic                stat_clr_i,
    output logic [STAT_W-1:0]   stat_pkt_ok_o,
    output logic [STAT_W-1:0]   stat_pkt_drop_o,
    output logic [$clog2(DEPTH):0] stat_max_used_o
`endif
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int WORD_W = $bits(pkt_buf_word_t);

    wr_state_t        r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_commit_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_drop;

    logic [PTR_W-1:0] w_used;
    logic [PTR_W-1:0] w_base;
    logic             w_full;
    logic             w_attempt;
    logic             w_abort;
    logic             w_wr_en;
    logic             w_commit;
    logic             w_drop_evt;
    pkt_buf_word_t    w_wr_word;
    pkt_buf_word_t    w_rd_word;

    logic             r_rd_pend;
    logic [1:0]       r_skid_cnt;
    logic             r_skid_wr_sel;
    logic             r_skid_rd_sel;
    logic             r_sop_next;
    pkt_buf_word_t    r_skid [2];

    logic             w_readable;
    logic             w_pop;
    logic             w_issue;
    logic [2:0]       w_occ_after;

    // NOTE: every signal here is assigned on every pass, so no latch is inferred.
    always_comb begin
        w_used     = r_wr_ptr - r_rd_ptr;
        w_full     = (w_used == PTR_W'(DEPTH));
        // A word is a write candidate when it opens a packet or continues one.
        w_attempt  = snk_val_i && (snk_sop_i || (r_state == WR));
        w_abort    = snk_val_i && snk_sop_i && (r_state == WR);
        w_base     = snk_sop_i ? r_commit_ptr : r_wr_ptr;
        w_wr_en    = w_attempt && !w_full;
        w_commit   = w_wr_en && snk_eop_i && !snk_err_i;
        w_drop_evt = w_attempt && (w_full || w_abort || (snk_eop_i && snk_err_i));
        w_wr_word  = '{eop: snk_eop_i, mty: snk_mty_i, data: snk_data_i};
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk_156m25_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_drop <= w_drop_evt;
            if (w_attempt) begin
                if (w_full) begin
                    r_wr_ptr <= r_commit_ptr;
                    r_state  <= snk_eop_i ? IDLE : DISCARD;
                end else if (snk_eop_i) begin
                    r_state <= IDLE;
                    if (snk_err_i) begin
                        r_wr_ptr <= r_commit_ptr;
                    end else begin
                        r_wr_ptr     <= w_base + 1'b1;
                        r_commit_ptr <= w_base + 1'b1;
                    end
                end else begin
                    r_wr_ptr <= w_base + 1'b1;
                    r_state  <= WR;
                end
            end else if (snk_val_i && snk_eop_i && (r_state == DISCARD)) begin
                r_state <= IDLE;
            end
        end
    end

    mx_pkt_buf_ram #(
        .W  (WORD_W),
        .AW (AW)
    ) u_ram (
        .i_clk     (clk_156m25_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_base[AW-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_word)
    );

    // Reads are issued only while the skid plus the word in flight stays within 2 entries.
    always_comb begin
        w_readable  = (r_rd_ptr != r_commit_ptr);
        w_pop       = src_val_o && src_ready_i;
        w_occ_after = {1'b0, r_skid_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
        w_issue     = w_readable && (w_occ_after < 3'd2);
    end

    always_ff @(posedge clk_156m25_i) begin
        if (rst_i) begin
            r_rd_ptr      <= '0;
            r_rd_pend     <= 1'b0;
            r_skid_cnt    <= 2'd0;
            r_skid_wr_sel <= 1'b0;
            r_skid_rd_sel <= 1'b0;
            r_sop_next    <= 1'b1;
            r_skid[0]     <= '0;
            r_skid[1]     <= '0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (r_rd_pend) begin
                r_skid[r_skid_wr_sel] <= w_rd_word;
                r_skid_wr_sel         <= !r_skid_wr_sel;
            end
            if (w_pop) begin
                r_skid_rd_sel <= !r_skid_rd_sel;
                r_sop_next    <= src_eop_o;
            end
            r_skid_cnt <= r_skid_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
        end
    end

    assign src_val_o  = (r_skid_cnt != 2'd0);
    assign src_sop_o  = src_val_o && r_sop_next;
    assign src_eop_o  = r_skid[r_skid_rd_sel].eop;
    assign src_mty_o  = r_skid[r_skid_rd_sel].mty;
    assign src_data_o = r_skid[r_skid_rd_sel].data;
    assign pkt_drop_o = r_drop;

`ifdef MX_PKT_BUF_STAT_EN
    logic [STAT_W-1:0] r_stat_ok;
    logic [STAT_W-1:0] r_stat_drop;
    logic [PTR_W-1:0]  r_max_used;

    always_ff @(posedge clk_156m25_i) begin
        if (rst_i || stat_clr_i) begin
            r_stat_ok   <= '0;
            r_stat_drop <= '0;
            r_max_used  <= '0;
        end else begin
            if (w_commit) begin
                r_stat_ok <= sat_inc(r_stat_ok);
            end
            if (w_drop_evt) begin
                r_stat_drop <= sat_inc(r_stat_drop);
            end
            if (w_used > r_max_used) begin
                r_max_used <= w_used;
            end
        end
    end

    assign stat_pkt_ok_o   = r_stat_ok;
    assign stat_pkt_drop_o = r_stat_drop;
    assign stat_max_used_o = r_max_used;
`endif

endmodule

// File: tb/tb_mx_pkt_to_cpu_buf.sv
// Scoreboard bench for mx_pkt_to_cpu_buf: stimulus pushes expected words into a
// queue, an independent monitor pops and compares on every accepted output word.
module tb_mx_pkt_to_cpu_buf;

    localparam int DEPTH = 256;
    localparam int DW    = 64;
    localparam int MW    = 3;
    localparam int SKID  = 2;
    localparam int OW    = 3 + MW + DW;

    typedef struct packed {
        logic          val;
        logic          sop;
        logic          eop;
        logic [MW-1:0] mty;
        logic [DW-1:0] data;
    } out_word_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          snk_val_i = 1'b0;
    logic          snk_sop_i = 1'b0;
    logic          snk_eop_i = 1'b0;
    logic [MW-1:0] snk_mty_i = '0;
    logic          snk_err_i = 1'b0;
    logic [DW-1:0] snk_data_i = '0;
    logic          src_ready_i = 1'b0;
    logic          src_val_o;
    logic          src_sop_o;
    logic          src_eop_o;
    logic [MW-1:0] src_mty_o;
    logic [DW-1:0] src_data_o;
    logic          pkt_drop_o;

    mx_pkt_to_cpu_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DW),
        .MTY_W  (MW)
    ) dut (
        .clk_156m25_i (clk),
        .rst_i        (rst_i),
        .snk_val_i    (snk_val_i),
        .snk_sop_i    (snk_sop_i),
        .snk_eop_i    (snk_eop_i),
        .snk_mty_i    (snk_mty_i),
        .snk_err_i    (snk_err_i),
        .snk_data_i   (snk_data_i),
        .src_val_o    (src_val_o),
        .src_sop_o    (src_sop_o),
        .src_eop_o    (src_eop_o),
        .src_mty_o    (src_mty_o),
        .src_data_o   (src_data_o),
        .src_ready_i  (src_ready_i),
        .pkt_drop_o   (pkt_drop_o)
    );

    initial forever #5 clk = ~clk;

    out_word_t exp_q[$];
    int n_checks  = 0;
    int n_errors  = 0;
    int drop_cnt  = 0;
    int exp_drops = 0;
    int out_words = 0;
    int out_pkts  = 0;
    bit rand_ready = 1'b0;
    // Reference capacity model, used only while the consumer is held off.
    bit m_hold = 1'b0;
    int m_held = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input bit sop, input bit eop, input logic [MW-1:0] mty,
                         input bit err, input logic [DW-1:0] data);
        snk_val_i  = 1'b1;
        snk_sop_i  = sop;
        snk_eop_i  = eop;
        snk_mty_i  = mty;
        snk_err_i  = err;
        snk_data_i = data;
        @(posedge clk);
        #1;
        snk_val_i = 1'b0;
        snk_sop_i = 1'b0;
        snk_eop_i = 1'b0;
        snk_err_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A packet survives when it is error-free and, with the consumer stalled,
    // fits in the buffer plus the 2-word output stage.
    task automatic send_pkt(input int len, input bit err);
        bit keep;
        out_word_t w;
        keep = !err && (!m_hold || (m_held + len <= DEPTH + SKID));
        if (keep && m_hold) m_held += len;
        if (!keep) exp_drops++;
        for (int i = 0; i < len; i++) begin
            w.val  = 1'b1;
            w.sop  = (i == 0);
            w.eop  = (i == len - 1);
            w.mty  = w.eop ? MW'($urandom_range(0, 7)) : '0;
            w.data = {$urandom, $urandom};
            if (keep) exp_q.push_back(w);
            drive(w.sop, w.eop, w.mty, err && w.eop, w.data);
        end
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_drops"}, drop_cnt, exp_drops);
    endtask

    initial begin : monitor
        out_word_t cur;
        out_word_t prev;
        out_word_t e;
        bit prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                cur = '{val: src_val_o, sop: src_sop_o, eop: src_eop_o, mty: src_mty_o, data: src_data_o};
                if (prev_stall) check_vec("stall_hold", cur, prev);
                if (src_val_o && src_ready_i) begin
                    out_words++;
                    if (src_eop_o) out_pkts++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got %0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check_vec("out_word", cur, e);
                    end
                end
                if (pkt_drop_o) drop_cnt++;
                prev_stall = src_val_o && !src_ready_i;
                prev = cur;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) src_ready_i = ($urandom_range(0, 1) == 1);
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int w0;
        int p0;
        int d0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_vec("rst_outputs", {src_val_o, src_sop_o, src_eop_o, src_mty_o, src_data_o}, '0);
        check("rst_drop", int'(pkt_drop_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Three back-to-back 8-word packets
        src_ready_i = 1'b1;
        w0 = out_words;
        p0 = out_pkts;
        repeat (3) send_pkt(8, 1'b0);
        drain("t1");
        check("t1_words", out_words - w0, 24);
        check("t1_pkts", out_pkts - p0, 3);

        // Errored packet, then commit-to-output latency on the next one
        d0 = drop_cnt;
        w0 = out_words;
        send_pkt(4, 1'b1);
        idle(3);
        check("t2_err_drop", drop_cnt - d0, 1);
        check("t2_no_output", out_words - w0, 0);
        send_pkt(5, 1'b0);
        @(negedge clk);
        check("t2_lat_c0", int'(src_val_o), 0);
        @(negedge clk);
        check("t2_lat_c1", int'(src_val_o), 0);
        @(negedge clk);
        check("t2_lat_c2", int'(src_val_o), 1);
        drain("t2");

        // sop at word 5 without a prior eop
        d0 = drop_cnt;
        drive(1'b1, 1'b0, '0, 1'b0, {$urandom, $urandom});
        repeat (4) drive(1'b0, 1'b0, '0, 1'b0, {$urandom, $urandom});
        exp_drops++;
        send_pkt(6, 1'b0);
        drain("t4");
        check("t4_abort_drop", drop_cnt - d0, 1);

        // Packet longer than the buffer can never commit
        src_ready_i = 1'b0;
        m_hold = 1'b1;
        m_held = 0;
        d0 = drop_cnt;
        w0 = out_words;
        send_pkt(300, 1'b0);
        idle(4);
        check("t4b_long_drop", drop_cnt - d0, 1);
        src_ready_i = 1'b1;
        drain("t4b");
        check("t4b_no_output", out_words - w0, 0);

        // Overflow with the consumer stalled
        src_ready_i = 1'b0;
        m_held = 0;
        d0 = drop_cnt;
        w0 = out_words;
        p0 = out_pkts;
        repeat (40) send_pkt(8, 1'b0);
        idle(4);
        check("t3_drops", drop_cnt - d0, 8);
        m_hold = 1'b0;
        src_ready_i = 1'b1;
        drain("t3");
        check("t3_words", out_words - w0, 256);
        check("t3_pkts", out_pkts - p0, 32);

        // Random traffic, random back-pressure, stray non-sop words
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) drive(1'b0, 1'b0, '0, 1'b0, {$urandom, $urandom});
            send_pkt(int'($urandom_range(1, 10)), ($urandom_range(0, 9) == 0));
            idle(int'($urandom_range(0, 4)));
        end
        drain("t5");
        rand_ready = 1'b0;
        src_ready_i = 1'b1;

        // Reset mid-packet on both sides
        idle(1);
        src_ready_i = 1'b0;
        send_pkt(8, 1'b0);
        idle(4);
        drive(1'b1, 1'b0, '0, 1'b0, {$urandom, $urandom});
        repeat (2) drive(1'b0, 1'b0, '0, 1'b0, {$urandom, $urandom});
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_val_after_rst", int'(src_val_o), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        src_ready_i = 1'b1;
        w0 = out_words;
        send_pkt(6, 1'b0);
        drain("t6");
        check("t6_words", out_words - w0, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
